// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access kinds, access sizes, request FSM states.
package mem_pkg;

    // is_dmem encodings; 2'b00 and 2'b11 both mean "no memory access"
    localparam logic [1:0] DMEM_LOAD  = 2'b01;
    localparam logic [1:0] DMEM_STORE = 2'b10;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } mem_state_e;

    // Doubleword only exists on a 64-bit datapath; elsewhere it behaves as a word
    function automatic logic [1:0] eff_size(input logic [1:0] size, input int data_w);
        if (size == SIZE_D && data_w != 64)
            return SIZE_W;
        return size;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data aligner: pulls the addressed bytes out of the raw DCache word and extends them.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            raw_data,
    input  logic [$clog2(DATA_W/8)-1:0]  lane,
    input  logic [1:0]                   size,
    input  logic                         is_unsigned,
    output logic [DATA_W-1:0]            load_data
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] sign_pos;
    logic              sign_bit;

    assign shifted = raw_data >> {lane, 3'b000};

    always_comb begin
        mask = '1;
        case (size)
            SIZE_B:  mask = DATA_W'(8'hFF);
            SIZE_H:  mask = DATA_W'(16'hFFFF);
            SIZE_W:  mask = DATA_W'(32'hFFFF_FFFF);
            default: mask = '1;
        endcase
    end

    // The sign bit sits at the top set bit of the size mask
    assign sign_pos  = mask ^ (mask >> 1);
    assign sign_bit  = |(shifted & sign_pos);
    assign load_data = (shifted & mask) | ((sign_bit && !is_unsigned) ? ~mask : '0);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: result select, DCache request FSM, load alignment, stall/flush.
// Optional MEM_ALIGN_CHK_EN adds the 'ale' misalignment output instead of forcing alignment.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int N_SRC  = 2,
    parameter int SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [1:0]              is_dmem,
    input  logic [1:0]              mem_size,
    input  logic                    mem_unsigned,
    input  logic [SEL_W-1:0]        cal_sel,
    input  logic [N_SRC*DATA_W-1:0] cal_bus,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       st_data,
    output logic                    dc_req_valid,
    input  logic                    dc_req_ready,
    output logic                    dc_req_we,
    output logic [ADDR_W-1:0]       dc_req_addr,
    output logic [DATA_W/8-1:0]     dc_req_wstrb,
    output logic [DATA_W-1:0]       dc_req_wdata,
    input  logic                    dc_resp_valid,
    input  logic [DATA_W-1:0]       dc_resp_data,
    output logic                    wb_valid,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    stall,
    output logic                    flush
`ifdef MEM_ALIGN_CHK_EN
    ,
    output logic                    ale
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);

    mem_state_e          state, state_n;
    logic [DATA_W-1:0]   load_buf, load_aligned, cal_result, wb_data_c, wdata_rep;
    logic [1:0]          size_e;
    logic [LANE_W-1:0]   lane_raw, lane_mask, lane;
    logic [STRB_W-1:0]   strb_base;
    logic [ADDR_W-1:0]   req_addr;
    logic                is_load, is_store, access;
    logic                req_valid_c, stall_c, wb_valid_c, capture;

    assign size_e   = eff_size(mem_size, DATA_W);
    assign is_load  = (is_dmem == DMEM_LOAD);
    assign is_store = (is_dmem == DMEM_STORE);
    assign access   = in_valid && (is_load || is_store);
    assign lane_raw = addr[LANE_W-1:0];

    always_comb begin
        lane_mask = '1;
        case (size_e)
            SIZE_B:  lane_mask = '0;
            SIZE_H:  lane_mask = LANE_W'(1);
            SIZE_W:  lane_mask = LANE_W'(3);
            default: lane_mask = '1;
        endcase
    end

`ifdef MEM_ALIGN_CHK_EN
    logic misaligned, ale_c;
    assign misaligned = |(lane_raw & lane_mask);
    assign lane       = lane_raw;
    assign req_addr   = addr;
`else
    // Without the checker, sub-size address bits are simply dropped
    assign lane       = lane_raw & ~lane_mask;
    assign req_addr   = {addr[ADDR_W-1:LANE_W], lane};
`endif

    always_comb begin
        cal_result = cal_bus[DATA_W-1:0];
        for (int i = 1; i < N_SRC; i++)
            if (int'(cal_sel) == i)
                cal_result = cal_bus[i*DATA_W +: DATA_W];
    end

    always_comb begin
        strb_base = STRB_W'(1);
        wdata_rep = st_data;
        case (size_e)
            SIZE_B: begin
                strb_base = STRB_W'(1);
                wdata_rep = {STRB_W{st_data[7:0]}};
            end
            SIZE_H: begin
                strb_base = STRB_W'(2'b11);
                wdata_rep = {(DATA_W/16){st_data[15:0]}};
            end
            SIZE_W: begin
                strb_base = STRB_W'(4'hF);
                wdata_rep = {(DATA_W/32){st_data[31:0]}};
            end
            default: begin
                strb_base = '1;
                wdata_rep = st_data;
            end
        endcase
    end

    mem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .raw_data    (dc_resp_data),
        .lane        (lane),
        .size        (size_e),
        .is_unsigned (mem_unsigned),
        .load_data   (load_aligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            load_buf <= '0;
        end else begin
            state <= state_n;
            if (capture)
                load_buf <= load_aligned;
        end
    end

    always_comb begin
        state_n     = state;
        req_valid_c = 1'b0;
        stall_c     = 1'b0;
        wb_valid_c  = 1'b0;
        wb_data_c   = cal_result;
        capture     = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
        ale_c       = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (in_valid && !access) begin
                    wb_valid_c = 1'b1;
                end else if (access) begin
`ifdef MEM_ALIGN_CHK_EN
                    if (misaligned)
                        ale_c = 1'b1;
                    else
`endif
                    begin
                        req_valid_c = 1'b1;
                        if (is_load) begin
                            stall_c = 1'b1;
                            state_n = dc_req_ready ? ST_WAIT : ST_REQ;
                        end else if (!dc_req_ready) begin
                            stall_c = 1'b1;
                            state_n = ST_REQ;
                        end
                    end
                end
            end
            ST_REQ: begin
                req_valid_c = 1'b1;
                stall_c     = 1'b1;
                if (dc_req_ready) begin
                    state_n = is_store ? ST_IDLE : ST_WAIT;
                    stall_c = !is_store;
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                if (dc_resp_valid) begin
                    capture = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_valid_c = 1'b1;
                wb_data_c  = load_buf;
                state_n    = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Handshake and hazard outputs are held low for as long as reset is asserted
    assign dc_req_valid = rst && req_valid_c;
    assign stall        = rst && stall_c;
    assign wb_valid     = rst && wb_valid_c;
    assign wb_data      = wb_data_c;
    assign dc_req_we    = is_store;
    assign dc_req_addr  = req_addr;
    assign dc_req_wstrb = is_store ? (strb_base << lane) : '0;
    assign dc_req_wdata = wdata_rep;
`ifdef MEM_ALIGN_CHK_EN
    assign ale          = rst && ale_c;
    assign flush        = rst && (stall_c || ale_c);
`else
    assign flush        = rst && stall_c;
`endif

endmodule
